// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported RAM between fetch and data requesters; data has priority,
// fetch is granted after STARVE_MAX back-to-back data grants. Optional counters: ARB_STATS_EN.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned STARVE_MAX     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ack,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              bus_err,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ready
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]       stat_if_grants,
  output logic [31:0]       stat_mem_grants,
  output logic [31:0]       stat_stall_cycles
`endif
);

  localparam int unsigned StreakW = $clog2(STARVE_MAX + 1);
  localparam int unsigned TimerW  = $clog2(TIMEOUT_CYCLES);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [1:0]         state_q, state_d;
  logic               owner_q, owner_d;  // 1 = data port owns the transaction
  logic               we_q, we_d;
  logic               err_q, err_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]  mem_rdata_q, mem_rdata_d;
  logic [StreakW-1:0] streak_q, streak_d;
  logic [TimerW-1:0]  timer_q, timer_d;
  logic               grant, grant_data;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    err_d       = err_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    streak_d    = streak_q;
    timer_d     = timer_q;
    grant       = 1'b0;
    grant_data  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (if_req || mem_req) begin
          grant      = 1'b1;
          grant_data = mem_req && !(if_req && (streak_q == StreakW'(STARVE_MAX)));
          owner_d    = grant_data;
          we_d       = grant_data & mem_we;
          addr_d     = grant_data ? mem_addr : if_addr;
          wdata_d    = grant_data ? mem_wdata : '0;
          err_d      = 1'b0;
          timer_d    = '0;
          state_d    = StBusy;
          // Streak only grows while fetch is actually waiting
          if (grant_data && if_req) begin
            if (streak_q != StreakW'(STARVE_MAX)) streak_d = streak_q + StreakW'(1);
          end else begin
            streak_d = '0;
          end
        end
      end
      StBusy: begin
        if (ram_ready) begin
          if (owner_q) mem_rdata_d = ram_rdata;
          else         if_rdata_d  = ram_rdata;
          state_d = StResp;
        end else if (timer_q == TimerW'(TIMEOUT_CYCLES - 1)) begin
          if (owner_q) mem_rdata_d = '0;
          else         if_rdata_d  = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      streak_q    <= '0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      err_q       <= err_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      streak_q    <= streak_d;
      timer_q     <= timer_d;
    end
  end

  always_comb begin
    ram_req   = (state_q == StBusy);
    ram_we    = ram_req & we_q;
    ram_addr  = addr_q;
    ram_wdata = wdata_q;
    if_ack    = (state_q == StResp) & ~owner_q;
    mem_ack   = (state_q == StResp) & owner_q;
    bus_err   = (state_q == StResp) & err_q;
    if_rdata  = if_rdata_q;
    mem_rdata = mem_rdata_q;
  end

`ifdef ARB_STATS_EN
  logic [31:0] if_grants_q, if_grants_d;
  logic [31:0] mem_grants_q, mem_grants_d;
  logic [31:0] stall_q, stall_d;

  always_comb begin
    if_grants_d  = if_grants_q;
    mem_grants_d = mem_grants_q;
    stall_d      = stall_q;
    if (grant && !grant_data) if_grants_d = if_grants_q + 32'd1;
    if (grant && grant_data)  mem_grants_d = mem_grants_q + 32'd1;
    if ((if_req && !if_ack) || (mem_req && !mem_ack)) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      if_grants_q  <= '0;
      mem_grants_q <= '0;
      stall_q      <= '0;
    end else begin
      if_grants_q  <= if_grants_d;
      mem_grants_q <= mem_grants_d;
      stall_q      <= stall_d;
    end
  end

  always_comb begin
    stat_if_grants    = if_grants_q;
    stat_mem_grants   = mem_grants_q;
    stat_stall_cycles = stall_q;
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized bench for mem_port_arbiter against a transaction-level model
// (owner choice from the streak rule, latency from wait count, RAM returns a chosen word).
module tb_mem_port_arbiter;
  localparam int SM = 4;
  localparam int TO = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0, mem_req = 1'b0, mem_we = 1'b0, ram_ready = 1'b0;
  logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0, ram_rdata = '0;
  logic        if_ack, mem_ack, bus_err, ram_req, ram_we;
  logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata;

  always #5 clock = ~clock;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_MAX(SM), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .bus_err(bus_err),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ready(ram_ready)
  );

  int          checks = 0;
  int          failures = 0;
  int          streak = 0;
  logic [31:0] last_if_rd = '0;
  logic [31:0] last_mem_rd = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Entered just after a rising edge with the DUT idle and requests driven; leaves it idle.
  task automatic txn(input string tag, input int waits, input logic [31:0] rd, output bit own);
    bit          done, err;
    int          k;
    logic [31:0] exp_addr, exp_rd;
    logic        exp_we;
    chk({tag, ":idle_ram_req"}, 32'(ram_req), 32'd0);
    own = mem_req && !(if_req && streak == SM);
    if (own && if_req) streak = (streak < SM) ? streak + 1 : SM;
    else               streak = 0;
    exp_addr = own ? mem_addr : if_addr;
    exp_we   = own & mem_we;
    err      = (waits >= TO);
    exp_rd   = err ? 32'd0 : rd;
    done = 1'b0;
    k    = 0;
    tick();
    while (!done) begin
      chk({tag, ":busy_ram_req"}, 32'(ram_req), 32'd1);
      chk({tag, ":busy_addr"}, ram_addr, exp_addr);
      chk({tag, ":busy_we"}, 32'(ram_we), 32'(exp_we));
      if (exp_we) chk({tag, ":busy_wdata"}, ram_wdata, mem_wdata);
      chk({tag, ":busy_acks"}, 32'({if_ack, mem_ack}), 32'd0);
      if (k == waits) begin
        ram_ready = 1'b1;
        ram_rdata = rd;
        done = 1'b1;
      end else begin
        ram_ready = 1'b0;
        ram_rdata = $urandom;
      end
      if (k == TO - 1) done = 1'b1;
      k++;
      tick();
    end
    ram_ready = 1'b0;
    ram_rdata = $urandom;
    chk({tag, ":resp_if_ack"}, 32'(if_ack), 32'(!own));
    chk({tag, ":resp_mem_ack"}, 32'(mem_ack), 32'(own));
    chk({tag, ":resp_err"}, 32'(bus_err), 32'(err));
    chk({tag, ":resp_ram_req"}, 32'(ram_req), 32'd0);
    if (own) begin
      last_mem_rd = exp_rd;
      mem_req = 1'b0;
    end else begin
      last_if_rd = exp_rd;
      if_req = 1'b0;
    end
    chk({tag, ":if_rdata"}, if_rdata, last_if_rd);
    chk({tag, ":mem_rdata"}, mem_rdata, last_mem_rd);
    tick();
  endtask

  initial begin
    bit own;
    int waits;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_ram_req", 32'(ram_req), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_addr", ram_addr, 32'd0);
    chk("rst_ram_wdata", ram_wdata, 32'd0);
    chk("rst_acks", 32'({if_ack, mem_ack, bus_err}), 32'd0);
    chk("rst_rdata", if_rdata | mem_rdata, 32'd0);
    reset = 1'b1;
    tick();

    // Fetch with a zero-wait RAM
    if_req = 1'b1; if_addr = 32'h10;
    txn("t1", 0, 32'h0030_0513, own);
    chk("t1_owner", 32'(own), 32'd0);

    // Simultaneous requests: data first, fetch follows
    if_req = 1'b1; if_addr = 32'h14;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h100;
    txn("t2a", 0, 32'h1111_2222, own);
    chk("t2_first_owner", 32'(own), 32'd1);
    txn("t2b", 0, 32'h3333_4444, own);
    chk("t2_second_owner", 32'(own), 32'd0);

    // Both held: four data grants then one fetch, repeating
    for (int i = 0; i < 10; i++) begin
      if (!if_req) begin if_req = 1'b1; if_addr = $urandom & 32'hFFFC; end
      if (!mem_req) begin mem_req = 1'b1; mem_we = 1'b0; mem_addr = $urandom & 32'hFFFC; end
      txn("t3", 0, $urandom, own);
      chk("t3_owner", 32'(own), (i % 5 == 4) ? 32'd0 : 32'd1);
    end
    if_req = 1'b0; mem_req = 1'b0;
    tick();
    streak = 0;

    // Store with three wait cycles
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h200; mem_wdata = 32'hDEAD_BEEF;
    txn("t4", 3, 32'h5555_0000, own);

    // RAM never ready: abort after TO cycles, then a normal access
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h300;
    txn("t5", TO, 32'hAAAA_5555, own);
    if_req = 1'b1; if_addr = 32'h20;
    txn("t5_after", 1, 32'h0000_1234, own);

    // Reset pulsed mid-BUSY
    if_req = 1'b1; if_addr = 32'h40;
    tick();
    chk("t6_busy", 32'(ram_req), 32'd1);
    reset = 1'b0;
    #1;
    chk("t6_ram_req", 32'(ram_req), 32'd0);
    chk("t6_acks", 32'({if_ack, mem_ack, bus_err}), 32'd0);
    chk("t6_ram_addr", ram_addr, 32'd0);
    chk("t6_rdata", if_rdata | mem_rdata, 32'd0);
    if_req = 1'b0;
    tick();
    reset = 1'b1;
    streak = 0; last_if_rd = '0; last_mem_rd = '0;
    tick();
    if_req = 1'b1; if_addr = 32'h10;
    txn("t6_fetch", 0, 32'h0030_0513, own);

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      if (!if_req && ($urandom % 2 == 0)) begin
        if_req = 1'b1; if_addr = $urandom;
      end
      if (!mem_req && ($urandom % 3 != 0)) begin
        mem_req = 1'b1; mem_we = 1'($urandom % 2); mem_addr = $urandom; mem_wdata = $urandom;
      end
      if (!if_req && !mem_req) begin
        if_req = 1'b1; if_addr = $urandom;
      end
      waits = ($urandom % 10 == 0) ? TO : int'($urandom % 4);
      txn("rnd", waits, $urandom, own);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
